hpm_ctrl: RTL and testbench
===========================

HPM_CTRL -- requirements
Module: hpm_ctrl

Interface
REQ-001 SHALL have parameter NCNT, default 4, giving the number of programmable counters mhpmcounter3..(2+NCNT); legal values are 1..29.
REQ-002 SHALL have parameter NEVT, default 8, giving the number of event inputs; legal values are 1..255.
REQ-003 SHALL have port clk_free, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port evt_in, input, NEVT bits: one-cycle event pulses; bit k is event index k+1.
REQ-006 SHALL have port prv, input, 2 bits: current privilege level (U=0, S=1, M=3).
REQ-007 SHALL have port csr_wr, input, 1 bit: CSR write strobe.
REQ-008 SHALL have port csr_waddr, input, 12 bits: CSR write address.
REQ-009 SHALL have port csr_wdata, input, XLEN bits: fully resolved write value (set/clear already applied).
REQ-010 SHALL have port csr_raddr, input, 12 bits: CSR read address.
REQ-011 SHALL have port csr_rdata, output, XLEN bits: read data; 0 on a miss.
REQ-012 SHALL have port csr_hit, output, 1 bit: csr_raddr decodes to a register owned by this block.
REQ-013 SHALL have port ovf_irq, output, 1 bit: local counter-overflow interrupt request, as a level.

Function
REQ-014 SHALL support XLEN=64 only; high-half CSRs SHALL NOT hit.
REQ-015 SHALL own the following registers.
- mcountinhibit at 0x320: bits [2+NCNT:3] writable, all other bits read 0.
- mhpmevent(3+i) at 0x323+i: bit 63 OF, bit 62 MINH, bit 61 SINH, bit 60 UINH, bits [7:0] EVSEL; all other bits read 0.
- mhpmcounter(3+i) at 0xB03+i: 64 bits.
- hpmcounter(3+i) at 0xC03+i: read-only alias of mhpmcounter(3+i).
REQ-016 SHALL register evt_in into evt_q (stage 1); a counter increments on the edge after evt_q is set, i.e. 2 edges after the evt_in pulse.
REQ-017 Counter i SHALL increment by 1 when all of the following hold.
- EVSEL != 0 and EVSEL <= NEVT.
- evt_q[EVSEL-1] is 1.
- mcountinhibit[3+i] is 0.
- The privilege inhibit bit for the prv sampled with evt_q is 0 (MINH for M, SINH for S, UINH for U).
REQ-018 SHALL sample prv into stage 1 alongside evt_q.
REQ-019 EVSEL 0 or EVSEL > NEVT SHALL never count.
REQ-020 Counter increment from 0xFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 and set OF in the same edge.
REQ-021 OF SHALL be sticky; only a CSR write to mhpmevent SHALL change it.
REQ-022 A CSR write to mhpmcounter(3+i) SHALL take priority over a same-cycle increment; that increment is lost and OF is not set.
REQ-023 A CSR write to mhpmevent(3+i) SHALL take effect for increments on the following edge.
REQ-024 A same-cycle wrap on a counter whose mhpmevent is being written SHALL have its OF result overwritten by the written OF value.
REQ-025 ovf_irq SHALL be registered: ovf_irq at edge N+1 equals OR over i of OF_i after edge N; it is 1 cycle after OF sets.
REQ-026 csr_rdata and csr_hit SHALL be combinational from csr_raddr and current register state.
REQ-027 A read in the same cycle as a write SHALL return the pre-write value.
REQ-028 Writes to unowned addresses, or to 0xC03+ aliases, SHALL be ignored.

Reset
REQ-029 On rstn=0 at a clock edge, SHALL clear all counters, mhpmevent, mcountinhibit, evt_q, the prv stage and ovf_irq.
REQ-030 Reset asserted mid-count SHALL discard any event pending in evt_q.
REQ-031 The first count after reset SHALL come from an evt_in pulse that is presented with rstn=1.

Structure
REQ-032 CSR addresses and mhpmevent bit positions (OF/MINH/SINH/UINH/EVSEL) SHALL be defined as constants in the shared CSR define package.
REQ-033 A per-counter sub-module hpm_counter (holding the counter, event register, increment qualification, wrap and OF logic) SHALL be instantiated NCNT times by a generate loop.

Verification
REQ-034 SHALL cover this scenario: EVSEL0=2, inhibit clear, prv=M, evt_in[1] pulse at cycle 10 -> mhpmcounter3 reads 1 from cycle 12, 0 before.
REQ-035 SHALL cover this scenario: mhpmcounter3 written 0xFFFF_FFFF_FFFF_FFFE, then 2 qualifying events -> counter 0, OF=1, ovf_irq=1 one cycle after the wrap.
REQ-036 SHALL cover this scenario: MINH=1 with prv=M, 5 events -> no count; prv=U with UINH=0, 5 events -> count 5.
REQ-037 SHALL cover this scenario: counter write 0x100 in the same cycle as a qualifying increment -> reads 0x100.
REQ-038 SHALL cover this scenario: mcountinhibit bit 3 set, events for 4 cycles -> count unchanged; clear the bit -> counting resumes.
REQ-039 SHALL cover this scenario: rstn pulsed while evt_q is set -> all reads return 0, ovf_irq=0, and no stray increment.

Source files
------------

// File: rtl/hpm_ctrl_pkg.sv
// Shared CSR definitions for the hardware performance monitor: addresses, mhpmevent field
// positions and the packed event-configuration type.
package hpm_ctrl_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [11:0] CsrMcountinhibit = 12'h320;
  localparam logic [11:0] CsrMhpmevent3    = 12'h323;
  localparam logic [11:0] CsrMhpmcounter3  = 12'hB03;
  localparam logic [11:0] CsrHpmcounter3   = 12'hC03;

  localparam int unsigned EvtOfBit   = 63;
  localparam int unsigned EvtMinhBit = 62;
  localparam int unsigned EvtSinhBit = 61;
  localparam int unsigned EvtUinhBit = 60;
  localparam int unsigned EvselW     = 8;

  typedef enum logic [1:0] {
    PrvU = 2'd0,
    PrvS = 2'd1,
    PrvM = 2'd3
  } prv_e;

  typedef struct packed {
    logic              of;
    logic              minh;
    logic              sinh;
    logic              uinh;
    logic [EvselW-1:0] evsel;
  } hpm_event_t;

  function automatic logic [XLEN-1:0] event_to_csr(input hpm_event_t e);
    logic [XLEN-1:0] r;
    r = '0;
    r[EvtOfBit]       = e.of;
    r[EvtMinhBit]     = e.minh;
    r[EvtSinhBit]     = e.sinh;
    r[EvtUinhBit]     = e.uinh;
    r[EvselW-1:0]     = e.evsel;
    return r;
  endfunction

  function automatic hpm_event_t csr_to_event(input logic [XLEN-1:0] d);
    hpm_event_t e;
    e.of    = d[EvtOfBit];
    e.minh  = d[EvtMinhBit];
    e.sinh  = d[EvtSinhBit];
    e.uinh  = d[EvtUinhBit];
    e.evsel = d[EvselW-1:0];
    return e;
  endfunction

endpackage

// File: rtl/hpm_ctrl_counter.sv
// One programmable performance counter with its event-select register, increment
// qualification, wrap and sticky overflow flag.
module hpm_counter
  import hpm_ctrl_pkg::*;
#(
  parameter int unsigned NEVT = 8
) (
  input  logic            clk_free,
  input  logic            rstn,
  input  logic [NEVT-1:0] evt_q,
  input  logic [1:0]      prv_q,
  input  logic            inhibit,
  input  logic            cnt_we,
  input  logic            evt_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] cnt,
  output hpm_event_t      cfg
);

  logic [XLEN-1:0] cnt_q;
  hpm_event_t      cfg_q;
  logic            evt_hit;
  logic            priv_inh;
  logic            inc;
  logic            wrap;

  // EVSEL 0 and EVSEL > NEVT match no k, so they never count.
  always_comb begin
    evt_hit = 1'b0;
    for (int k = 0; k < int'(NEVT); k++) begin
      if (cfg_q.evsel == EvselW'(k + 1)) evt_hit = evt_q[k];
    end
  end

  always_comb begin
    priv_inh = 1'b0;
    case (prv_e'(prv_q))
      PrvM:    priv_inh = cfg_q.minh;
      PrvS:    priv_inh = cfg_q.sinh;
      PrvU:    priv_inh = cfg_q.uinh;
      default: priv_inh = 1'b0;
    endcase
  end

  assign inc  = evt_hit & ~inhibit & ~priv_inh;
  assign wrap = inc & (&cnt_q);

  always_ff @(posedge clk_free) begin
    if (!rstn) begin
      cnt_q <= '0;
      cfg_q <= '0;
    end else begin
      if (cnt_we) begin
        cnt_q <= wdata;
      end else if (inc) begin
        cnt_q <= cnt_q + XLEN'(1);
      end
      // A counter write swallows the increment, so no wrap can be flagged then.
      if (evt_we) begin
        cfg_q <= csr_to_event(wdata);
      end else if (wrap && !cnt_we) begin
        cfg_q.of <= 1'b1;
      end
    end
  end

  assign cnt = cnt_q;
  assign cfg = cfg_q;

endmodule

// File: rtl/hpm_ctrl.sv
// Hardware performance monitor: event/privilege stage, mcountinhibit, NCNT counters,
// CSR read mux and registered overflow interrupt.
module hpm_ctrl
  import hpm_ctrl_pkg::*;
#(
  parameter int unsigned NCNT = 4,
  parameter int unsigned NEVT = 8
) (
  input  logic            clk_free,
  input  logic            rstn,
  input  logic [NEVT-1:0] evt_in,
  input  logic [1:0]      prv,
  input  logic            csr_wr,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic            ovf_irq
);

  logic [NEVT-1:0] evt_q;
  logic [1:0]      prv_q;
  logic [NCNT-1:0] inhibit_q;
  logic            ovf_q;

  logic [XLEN-1:0] cnt [NCNT];
  hpm_event_t      cfg [NCNT];
  logic [NCNT-1:0] of_vec;
  logic [NCNT-1:0] cnt_we;
  logic [NCNT-1:0] evt_we;
  logic            inh_we;

  assign inh_we = csr_wr && (csr_waddr == CsrMcountinhibit);

  always_ff @(posedge clk_free) begin
    if (!rstn) begin
      evt_q     <= '0;
      prv_q     <= '0;
      inhibit_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      evt_q <= evt_in;
      prv_q <= prv;
      if (inh_we) inhibit_q <= csr_wdata[NCNT+2:3];
      ovf_q <= |of_vec;
    end
  end

  for (genvar g = 0; g < int'(NCNT); g++) begin : g_cnt
    assign cnt_we[g] = csr_wr && (csr_waddr == CsrMhpmcounter3 + 12'(g));
    assign evt_we[g] = csr_wr && (csr_waddr == CsrMhpmevent3 + 12'(g));
    assign of_vec[g] = cfg[g].of;

    hpm_counter #(
      .NEVT (NEVT)
    ) u_counter (
      .clk_free (clk_free),
      .rstn     (rstn),
      .evt_q    (evt_q),
      .prv_q    (prv_q),
      .inhibit  (inhibit_q[g]),
      .cnt_we   (cnt_we[g]),
      .evt_we   (evt_we[g]),
      .wdata    (csr_wdata),
      .cnt      (cnt[g]),
      .cfg      (cfg[g])
    );
  end

  // Reads see register state before any same-cycle write lands.
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    if (csr_raddr == CsrMcountinhibit) begin
      csr_hit   = 1'b1;
      csr_rdata = XLEN'(inhibit_q) << 3;
    end
    for (int i = 0; i < int'(NCNT); i++) begin
      if (csr_raddr == CsrMhpmevent3 + 12'(i)) begin
        csr_hit   = 1'b1;
        csr_rdata = event_to_csr(cfg[i]);
      end
      if (csr_raddr == CsrMhpmcounter3 + 12'(i) || csr_raddr == CsrHpmcounter3 + 12'(i)) begin
        csr_hit   = 1'b1;
        csr_rdata = cnt[i];
      end
    end
  end

  assign ovf_irq = ovf_q;

endmodule

// File: tb/tb_hpm_ctrl.sv
// Bench for hpm_ctrl: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural model of the counter block.
module tb_hpm_ctrl;

  localparam int NCNT = 4;
  localparam int NEVT = 8;

  logic            clk_free = 1'b0;
  logic            rstn;
  logic [NEVT-1:0] evt_in;
  logic [1:0]      prv;
  logic            csr_wr;
  logic [11:0]     csr_waddr;
  logic [63:0]     csr_wdata;
  logic [11:0]     csr_raddr;
  logic [63:0]     csr_rdata;
  logic            csr_hit;
  logic            ovf_irq;

  always #5 clk_free = ~clk_free;

  hpm_ctrl #(
    .NCNT (NCNT),
    .NEVT (NEVT)
  ) dut (
    .clk_free  (clk_free),
    .rstn      (rstn),
    .evt_in    (evt_in),
    .prv       (prv),
    .csr_wr    (csr_wr),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .csr_hit   (csr_hit),
    .ovf_irq   (ovf_irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [63:0]     m_cnt   [NCNT];
  bit [7:0]      m_evsel [NCNT];
  bit            m_of    [NCNT];
  bit            m_minh  [NCNT];
  bit            m_sinh  [NCNT];
  bit            m_uinh  [NCNT];
  bit            m_inh   [NCNT];
  bit [NEVT-1:0] m_evtq;
  bit [1:0]      m_prvq;
  bit            m_ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_read(input logic [11:0] a, output bit hit, output bit [63:0] d);
    hit = 0;
    d   = '0;
    if (a == 12'h320) begin
      hit = 1;
      for (int i = 0; i < NCNT; i++) d[3+i] = m_inh[i];
    end
    for (int i = 0; i < NCNT; i++) begin
      if (a == 12'h323 + 12'(i)) begin
        hit = 1;
        d = {m_of[i], m_minh[i], m_sinh[i], m_uinh[i], 52'd0, m_evsel[i]};
      end
      if (a == 12'hB03 + 12'(i) || a == 12'hC03 + 12'(i)) begin
        hit = 1;
        d = m_cnt[i];
      end
    end
  endtask

  task automatic model_step();
    bit any_of;
    bit inc;
    bit pinh;
    if (!rstn) begin
      for (int i = 0; i < NCNT; i++) begin
        m_cnt[i] = 0; m_evsel[i] = 0; m_of[i] = 0;
        m_minh[i] = 0; m_sinh[i] = 0; m_uinh[i] = 0; m_inh[i] = 0;
      end
      m_evtq = 0; m_prvq = 0; m_ovf = 0;
    end else begin
      any_of = 0;
      for (int i = 0; i < NCNT; i++) any_of |= m_of[i];
      for (int i = 0; i < NCNT; i++) begin
        pinh = (m_prvq == 2'd3) ? m_minh[i] : (m_prvq == 2'd1) ? m_sinh[i] :
               (m_prvq == 2'd0) ? m_uinh[i] : 1'b0;
        inc = (m_evsel[i] != 0) && (int'(m_evsel[i]) <= NEVT) && !m_inh[i] && !pinh;
        if (inc) inc = m_evtq[int'(m_evsel[i]) - 1];
        if (csr_wr && csr_waddr == 12'hB03 + 12'(i)) begin
          m_cnt[i] = csr_wdata;
        end else if (inc) begin
          if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) begin
            m_cnt[i] = 0;
            m_of[i]  = 1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (csr_wr && csr_waddr == 12'h323 + 12'(i)) begin
          m_of[i]    = csr_wdata[63];
          m_minh[i]  = csr_wdata[62];
          m_sinh[i]  = csr_wdata[61];
          m_uinh[i]  = csr_wdata[60];
          m_evsel[i] = csr_wdata[7:0];
        end
      end
      if (csr_wr && csr_waddr == 12'h320) begin
        for (int i = 0; i < NCNT; i++) m_inh[i] = csr_wdata[3+i];
      end
      m_ovf  = any_of;
      m_evtq = evt_in;
      m_prvq = prv;
    end
  endtask

  task automatic compare_outputs();
    bit        h;
    bit [63:0] d;
    model_read(csr_raddr, h, d);
    check($sformatf("csr_hit@%h", csr_raddr), 64'(csr_hit), 64'(h));
    check($sformatf("csr_rdata@%h", csr_raddr), csr_rdata, d);
    check("ovf_irq", 64'(ovf_irq), 64'(m_ovf));
  endtask

  // Compare mid-cycle, then advance one edge; inputs are pulses that drop after the edge.
  task automatic tick();
    @(negedge clk_free);
    compare_outputs();
    @(posedge clk_free);
    model_step();
    #1;
    evt_in = '0;
    csr_wr = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_wr    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
  endtask

  task automatic peek(input logic [11:0] a, input logic [63:0] exp, input string name);
    csr_raddr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  function automatic logic [11:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 12'h320;
      1, 2:    return 12'h323 + 12'($urandom_range(0, NCNT));
      3, 4:    return 12'hB03 + 12'($urandom_range(0, NCNT));
      5:       return 12'hC03 + 12'($urandom_range(0, NCNT - 1));
      6:       return 12'hB83 + 12'($urandom_range(0, NCNT - 1));
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    rstn = 1'b0; evt_in = '0; prv = 2'd3; csr_wr = 1'b0;
    csr_waddr = '0; csr_wdata = '0; csr_raddr = 12'hB03;
    repeat (2) begin
      @(posedge clk_free);
      model_step();
      #1;
    end
    rstn = 1'b1;
    peek(12'hB03, 64'd0, "reset counter3");
    check("reset ovf_irq", 64'(ovf_irq), 64'd0);
    tick();

    // Single qualifying event: visible two edges after the pulse.
    csr_write(12'h323, 64'd2);
    csr_raddr = 12'hB03;
    tick();
    evt_in = 8'h02;
    tick();
    peek(12'hB03, 64'd0, "s034 before");
    tick();
    peek(12'hB03, 64'd1, "s034 after");
    check("s034 model pin", m_cnt[0], 64'd1);

    // Wrap from all-ones minus one after two events.
    csr_write(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
    evt_in = 8'h02; tick();
    evt_in = 8'h02; tick();
    peek(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, "s035 max");
    tick();
    peek(12'hB03, 64'd0, "s035 wrapped");
    peek(12'h323, 64'h8000_0000_0000_0002, "s035 OF set");
    check("s035 irq not yet", 64'(ovf_irq), 64'd0);
    tick();
    check("s035 irq", 64'(ovf_irq), 64'd1);
    check("s035 model irq pin", 64'(m_ovf), 64'd1);
    csr_write(12'h323, 64'd2);

    // Privilege inhibit: M inhibited, U counts.
    csr_write(12'h323, 64'h4000_0000_0000_0002);
    prv = 2'd3;
    repeat (5) begin evt_in = 8'h02; tick(); end
    tick(); tick();
    peek(12'hB03, 64'd0, "s036 minh");
    prv = 2'd0;
    repeat (5) begin evt_in = 8'h02; tick(); end
    tick(); tick();
    peek(12'hB03, 64'd5, "s036 user");

    // Counter write beats a same-edge increment.
    evt_in = 8'h02; tick();
    csr_write(12'hB03, 64'h100);
    peek(12'hB03, 64'h100, "s037 write wins");
    tick();
    peek(12'hB03, 64'h100, "s037 no late inc");

    // mcountinhibit freezes counter 3, then releases it.
    csr_write(12'h320, 64'h8);
    peek(12'h320, 64'h8, "s038 inhibit rd");
    repeat (4) begin evt_in = 8'h02; tick(); end
    tick(); tick();
    peek(12'hB03, 64'h100, "s038 frozen");
    csr_write(12'h320, 64'h0);
    repeat (2) begin evt_in = 8'h02; tick(); end
    tick(); tick();
    peek(12'hB03, 64'h102, "s038 resumed");
    peek(12'hC03, 64'h102, "alias read");

    // Reset while an event sits in evt_q.
    evt_in = 8'h02; tick();
    rstn = 1'b0; tick();
    rstn = 1'b1;
    peek(12'hB03, 64'd0, "s039 counter");
    peek(12'h323, 64'd0, "s039 event");
    peek(12'h320, 64'd0, "s039 inhibit");
    check("s039 irq", 64'(ovf_irq), 64'd0);
    tick(); tick();
    peek(12'hB03, 64'd0, "s039 no stray");

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [11:0] a;
      rstn      = ($urandom_range(0, 599) != 0);
      evt_in    = NEVT'($urandom);
      prv       = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      csr_raddr = pick_addr();
      if ($urandom_range(0, 3) == 0) begin
        a = pick_addr();
        csr_wr    = 1'b1;
        csr_waddr = a;
        csr_wdata = {$urandom, $urandom};
        if (a >= 12'h323 && a < 12'h323 + 12'(NCNT))
          csr_wdata[7:0] = 8'($urandom_range(0, NEVT + 2));
        if (a >= 12'hB03 && a < 12'hB03 + 12'(NCNT) && $urandom_range(0, 1) == 1)
          csr_wdata = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        if (a == 12'h320 && $urandom_range(0, 1) == 1)
          csr_wdata = '0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
